// File: rtl/cpu_pkg.sv
// Shared RV32I core constants: reset vector default, instruction size, NOP encoding.
// Pure declarations; no latency or flow control.
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES   = 32'd4;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
endpackage

// File: rtl/fetch_skid.sv
// One-entry pc/inst holding buffer; load captures on the edge, contents visible next cycle.
// No backpressure of its own: the owner only loads it while empty; clear wins over load and unload.
module fetch_skid (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        vld_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);
  logic        vld_q;
  logic [31:0] pc_q, inst_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q  <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else if (clear_i) begin
      vld_q  <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      pc_q   <= pc_i;
      inst_q <= inst_i;
    end else if (unload_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;
endmodule

// File: rtl/fetch.sv
// RV32I fetch: one outstanding imem read; RVALID at t presents I_* at t+1, 2 cycles/inst at best.
// STALL holds I_*; a response landing during a stall parks in the skid buffer and requests pause.
module fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] NEW_PC,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_GNT,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] I_PC,
  output logic [31:0] I_INST,
  output logic        I_VALID
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FULL} state_t;

  state_t      state_q;
  logic [31:0] fetch_pc_q, req_pc_q, i_pc_q, i_inst_q;
  logic        i_valid_q, drop_q;
  logic        slot_free, rsp_keep, sk_load, sk_unload, sk_vld;
  logic [31:0] sk_pc, sk_inst, next_pc_d;

  assign slot_free = !i_valid_q || !STALL;
  assign rsp_keep  = (state_q == S_WAIT) && MEM_RVALID && !drop_q && !FLUSH;
  assign sk_load   = rsp_keep && !slot_free;
  assign sk_unload = (state_q == S_FULL) && !STALL && !FLUSH;
  assign next_pc_d = req_pc_q + INST_BYTES;

  fetch_skid u_skid (
    .CLK      (CLK),
    .RST      (RST),
    .load_i   (sk_load),
    .unload_i (sk_unload),
    .clear_i  (FLUSH),
    .pc_i     (req_pc_q),
    .inst_i   (MEM_RDATA),
    .vld_o    (sk_vld),
    .pc_o     (sk_pc),
    .inst_o   (sk_inst)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      drop_q     <= 1'b0;
      i_pc_q     <= '0;
      i_inst_q   <= '0;
      i_valid_q  <= 1'b0;
    end else if (FLUSH) begin
      i_valid_q  <= 1'b0;
      fetch_pc_q <= NEW_PC;
      // Anything still in flight after this edge belongs to the old path.
      case (state_q)
        S_REQ: if (MEM_GNT) begin
          req_pc_q <= fetch_pc_q;
          drop_q   <= 1'b1;
          state_q  <= S_WAIT;
        end
        S_WAIT: if (MEM_RVALID) begin
          drop_q  <= 1'b0;
          state_q <= S_REQ;
        end else begin
          drop_q  <= 1'b1;
        end
        default: state_q <= S_REQ;
      endcase
    end else begin
      if (i_valid_q && !STALL) i_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: if (MEM_GNT) begin
          req_pc_q <= fetch_pc_q;
          state_q  <= S_WAIT;
        end
        S_WAIT: if (MEM_RVALID) begin
          if (drop_q) begin
            drop_q  <= 1'b0;
            state_q <= S_REQ;
          end else begin
            fetch_pc_q <= next_pc_d;
            if (slot_free) begin
              i_pc_q    <= req_pc_q;
              i_inst_q  <= MEM_RDATA;
              i_valid_q <= 1'b1;
              state_q   <= S_REQ;
            end else begin
              state_q   <= S_FULL;
            end
          end
        end
        S_FULL: if (!STALL && sk_vld) begin
          i_pc_q    <= sk_pc;
          i_inst_q  <= sk_inst;
          i_valid_q <= 1'b1;
          state_q   <= S_REQ;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign MEM_REQ  = (state_q == S_REQ);
  assign MEM_ADDR = fetch_pc_q;
  assign I_PC     = i_pc_q;
  assign I_INST   = i_inst_q;
  assign I_VALID  = i_valid_q;
endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the RV32I pipeline, directly upstream of decode. It issues one instruction-memory read at a time over a request/grant/response handshake and drives the `I_PC`/`I_INST`/`I_VALID` bundle that decode latches on every non-stalled cycle. A one-entry skid buffer absorbs a response that arrives while decode is stalled. Branch redirects (`FLUSH`/`NEW_PC`) discard stale in-flight data.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `CLK` input 1: clock, rising edge.
- `RST` input 1: **reset is asynchronous and active-low**; everything described as a reset value is forced while `RST`=0.
- `STALL` input 1: decode holds. An instruction on `I_*` is not consumed on a cycle where `STALL`=1.
- `FLUSH` input 1: redirect request from execute.
- `NEW_PC` input 32: redirect target; sampled only when `FLUSH`=1.
- `MEM_REQ` output 1: read request.
- `MEM_ADDR` output 32: read address; valid while `MEM_REQ`=1.
- `MEM_GNT` input 1: memory accepted the request this cycle.
- `MEM_RVALID` input 1: read data valid; exactly one response per grant, earliest the cycle after the grant.
- `MEM_RDATA` input 32: instruction word.
- `I_PC` output 32: PC of the presented instruction.
- `I_INST` output 32: presented instruction.
- `I_VALID` output 1: `I_PC`/`I_INST` hold a live instruction.

## Operation
- **Registers:**
  - `fetch_pc`: next address to request.
  - `req_pc`: PC of the in-flight request.
  - Output registers `I_PC`, `I_INST`, `I_VALID`.
  - Skid buffer: `sk_pc`, `sk_inst`.
  - `drop` flag.
  - FSM `state`.
- **Reset values:**
  - `state`=S_IDLE, `fetch_pc`=`RESET_PC`, `drop`=0.
  - `I_PC`=0, `I_INST`=0, `I_VALID`=0.
  - `MEM_REQ`=0, `MEM_ADDR`=`RESET_PC`.
- **Memory outputs:** `MEM_REQ` = (`state`==S_REQ). `MEM_ADDR` = `fetch_pc`.
- **Consumption:** on a clock edge with `I_VALID`=1 and `STALL`=0, the instruction is consumed. `I_VALID` then goes to 0 unless a new instruction is loaded on that same edge.
- **Output slot free:** the slot is free when `I_VALID`=0 or `STALL`=0.
- **State S_IDLE:** go to S_REQ next cycle.
- **State S_REQ:**
  - On `MEM_GNT`: `req_pc` <= `fetch_pc`, go to S_WAIT.
  - Without a grant, `MEM_ADDR` may change only through `FLUSH`.
- **State S_WAIT,** on `MEM_RVALID`:
  - If `drop`=1: discard the data, clear `drop`, go to S_REQ.
  - Else if the output slot is free: load `I_*` <= {`req_pc`, `MEM_RDATA`, 1}, `fetch_pc` <= `req_pc`+4, go to S_REQ.
  - Else: load the skid buffer, `fetch_pc` <= `req_pc`+4, go to S_FULL.
- **State S_FULL:** no request is issued. When `STALL`=0, move the skid buffer into `I_*` (`I_VALID`=1) and go to S_REQ.
- **FLUSH (dominates STALL and every other event):**
  - `I_VALID` <= 0 and the skid buffer is emptied.
  - `fetch_pc` <= `NEW_PC`.
  - If a request is outstanding after this edge, `drop` <= 1. That covers S_WAIT without `MEM_RVALID`, and S_REQ with `MEM_GNT`.
  - S_WAIT with `MEM_RVALID` in the same cycle: the data is discarded, go to S_REQ.
  - S_REQ without `MEM_GNT`: stay in S_REQ; `MEM_ADDR` shows `NEW_PC` next cycle.
  - S_FULL or S_IDLE: go to S_REQ.
  - A `FLUSH` while `drop`=1 keeps `drop`=1; the last `NEW_PC` wins.
- **PC arithmetic:** +4, modulo 2^32; 32'hFFFF_FFFC wraps to 0. No alignment check.

## Timing
- All outputs are registered or decoded from `state`/`fetch_pc`. There are no combinational paths from inputs to outputs.
- First `MEM_REQ` is in the second cycle after `RST` deasserts.
- Response to output: `MEM_RVALID` at cycle t gives `I_VALID`=1 at t+1.
- With zero-wait memory (grant in the request cycle, data the next cycle):
  - Request at t, data at t+1, instruction presented at t+2, next request at t+2.
  - Throughput is one instruction per 2 cycles.
- At most one outstanding request.

## Structure
- The shared `cpu_pkg` holds:
  - The `RESET_PC` default.
  - The instruction size constant 4.
  - The NOP encoding 32'h0000_0013 (for benches).
- FSM encodings (S_IDLE, S_REQ, S_WAIT, S_FULL) stay local to `fetch`.
- One sub-module, `fetch_skid`: a 1-entry pc/inst buffer with load, unload and clear.

## Test plan
- **Reset and streaming:** reset with `RESET_PC`=0x100, zero-wait memory returning addr^0xA5A5_0000 -> `I_PC` sequence 0x100, 0x104, 0x108; `I_VALID` pulses every 2nd cycle; first `MEM_REQ` 2 cycles after reset release.
- **Stall with skid:** `STALL`=1 for 5 cycles while instruction 0x104 is presented and 0x108 returns -> 0x104 is held, 0x108 sits in the skid buffer, no `MEM_REQ` during S_FULL; 0x108 is presented the cycle after `STALL` falls.
- **Flush mid-flight:** `FLUSH` with `NEW_PC`=0x2000 while in S_WAIT, response arrives 3 cycles later -> that response is dropped, next `MEM_ADDR`=0x2000, first presented `I_PC`=0x2000.
- **Simultaneous events:**
  - `FLUSH`+`MEM_GNT` in one cycle -> `drop`=1.
  - `FLUSH`+`MEM_RVALID` in one cycle -> the data is discarded.
  - `FLUSH`+`STALL` -> `I_VALID`=0 on the next cycle.
- **Wrap-around:** `NEW_PC`=0xFFFF_FFFC -> following fetch address is 0x0000_0000.
- **Async reset mid-operation:** assert `RST`=0 between clock edges during S_WAIT -> `MEM_REQ`=0 and `I_VALID`=0 immediately; a late `MEM_RVALID` is ignored.
